// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator types: FSM states, operation codes, key codes
package calc_pkg;

    localparam int CALC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } calc_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        ADD      = 3'd0,
        SUB      = 3'd1,
        IGUAL    = 3'd2,
        SAVE     = 3'd3,
        RECOVERY = 3'd4
    } calc_key_t;

endpackage

// File: rtl/calc_serial_alu.sv
// rtl/calc_serial_alu.sv - bit-serial full adder with carry flop and MSB carry-in capture
module calc_serial_alu (
    input  logic clk,
    input  logic clr,
    input  logic load,
    input  logic carryInit,
    input  logic en,
    input  logic last,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carryOut,
    output logic msbCarryIn
);

    logic carry;

    assign sum      = a ^ b ^ carry;
    assign carryOut = carry;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            carry      <= 1'b0;
            msbCarryIn <= 1'b0;
        end else if (load) begin
            carry      <= carryInit;
            msbCarryIn <= 1'b0;
        end else if (en) begin
            carry <= (a & b) | (a & carry) | (b & carry);
            // The carry entering the MSB is needed later for signed overflow.
            if (last) begin
                msbCarryIn <= carry;
            end
        end
    end

endmodule

// File: rtl/calc_exec_sequencer.sv
// rtl/calc_exec_sequencer.sv - "=" step: bit-serial add/sub, result publish, memory write arbiter
module calc_exec_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             Clock,
    input  logic             clearIn,
    input  logic             start,
    input  logic [WIDTH-1:0] numberA,
    input  logic [WIDTH-1:0] numberB,
    input  logic             operation,
    input  logic             autoSave,
    input  logic             memWrReq,
    input  logic [WIDTH-1:0] memWrData,
    output logic [WIDTH-1:0] result,
    output logic             resultValid,
    output logic             overflow,
    output logic             busy,
    output logic [WIDTH-1:0] memory,
    output logic             memWrAck
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    calc_state_t      state, stateNext;
    logic [WIDTH-1:0] aReg, bReg, sumReg;
    logic [CW-1:0]    bitCnt;
    logic             saveReg, pending;
    logic             startOk, lastBit, resultWrite;
    logic             aluSum, carryOut, msbCarryIn;

    assign startOk     = (state == IDLE) && start;
    assign lastBit     = (bitCnt == LAST_BIT);
    assign busy        = (state != IDLE);
    assign resultWrite = (state == DONE) && saveReg;

    calc_serial_alu u_alu (
        .clk        (Clock),
        .clr        (clearIn),
        .load       (startOk),
        .carryInit  (operation == OP_SUB),
        .en         (state == SHIFT),
        .last       (lastBit),
        .a          (aReg[0]),
        .b          (bReg[0]),
        .sum        (aluSum),
        .carryOut   (carryOut),
        .msbCarryIn (msbCarryIn)
    );

    always_ff @(posedge Clock or posedge clearIn) begin
        if (clearIn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = LOAD;
            LOAD:    stateNext = SHIFT;
            SHIFT:   if (lastBit) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge clearIn) begin
        if (clearIn) begin
            aReg        <= '0;
            bReg        <= '0;
            sumReg      <= '0;
            bitCnt      <= '0;
            saveReg     <= 1'b0;
            result      <= '0;
            resultValid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        aReg        <= numberA;
                        bReg        <= (operation == OP_SUB) ? ~numberB : numberB;
                        saveReg     <= autoSave;
                        resultValid <= 1'b0;
                    end
                end
                LOAD: bitCnt <= '0;
                SHIFT: begin
                    aReg   <= aReg >> 1;
                    bReg   <= bReg >> 1;
                    sumReg <= {aluSum, sumReg[WIDTH-1:1]};
                    bitCnt <= bitCnt + 1'b1;
                end
                DONE: begin
                    result      <= sumReg;
                    overflow    <= msbCarryIn ^ carryOut;
                    resultValid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // SAVE from the key FSM always wins; a colliding result write is deferred one cycle.
    always_ff @(posedge Clock or posedge clearIn) begin
        if (clearIn) begin
            memory   <= '0;
            memWrAck <= 1'b0;
            pending  <= 1'b0;
        end else begin
            memWrAck <= 1'b0;
            if (memWrReq) begin
                memory   <= memWrData;
                memWrAck <= 1'b1;
                if (resultWrite) begin
                    pending <= 1'b1;
                end
            end else if (resultWrite) begin
                memory   <= sumReg;
                memWrAck <= 1'b1;
                pending  <= 1'b0;
            end else if (pending) begin
                memory   <= result;
                memWrAck <= 1'b1;
                pending  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc_exec_sequencer.sv
// tb/tb_calc_exec_sequencer.sv - scoreboard bench for calc_exec_sequencer
module tb_calc_exec_sequencer;

    logic       Clock = 1'b0;
    logic       clearIn = 1'b1;
    logic       start = 1'b0;
    logic [7:0] numberA = '0, numberB = '0, memWrData = '0;
    logic       operation = 1'b0, autoSave = 1'b0, memWrReq = 1'b0;
    logic [7:0] result, memory;
    logic       resultValid, overflow, busy, memWrAck;

    typedef struct {
        logic [7:0] res;
        logic       ov;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] memQ[$];
    int         checks = 0;
    int         errors = 0;
    logic       prevValid = 1'b0;

    calc_exec_sequencer #(.WIDTH(8)) dut (
        .Clock       (Clock),
        .clearIn     (clearIn),
        .start       (start),
        .numberA     (numberA),
        .numberB     (numberB),
        .operation   (operation),
        .autoSave    (autoSave),
        .memWrReq    (memWrReq),
        .memWrData   (memWrData),
        .result      (result),
        .resultValid (resultValid),
        .overflow    (overflow),
        .busy        (busy),
        .memory      (memory),
        .memWrAck    (memWrAck)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares each new result and each memory write against the queues.
    always @(negedge Clock) begin
        if (!clearIn && resultValid && !prevValid) begin
            if (expQ.size() == 0) begin
                check("unexpected_result", 32'(result), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                check("sb_result", 32'(result), 32'(e.res));
                check("sb_overflow", 32'(overflow), 32'(e.ov));
            end
        end
        prevValid = resultValid;
        if (!clearIn && memWrAck) begin
            if (memQ.size() == 0) begin
                check("unexpected_memwr", 32'(memory), 32'hFFFF_FFFF);
            end else begin
                check("sb_memory", 32'(memory), 32'(memQ.pop_front()));
            end
        end
    end

    task automatic issueStart(input logic [7:0] a, input logic [7:0] b, input logic op,
                              input logic save);
        @(negedge Clock);
        numberA   = a;
        numberB   = b;
        operation = op;
        autoSave  = save;
        start     = 1'b1;
        @(negedge Clock);
        start   = 1'b0;
        numberA = ~a;
        numberB = 8'h5A;
    endtask

    task automatic waitValid(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge Clock);
            #1;
            n = i;
            if (resultValid) break;
        end
        check({name, "_latency"}, 32'(n), 32'd10);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic runOp(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic op, input logic save, input logic [7:0] res,
                         input logic ov);
        expQ.push_back('{res: res, ov: ov});
        if (save) memQ.push_back(res);
        issueStart(a, b, op, save);
        waitValid(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge Clock);
        check("rst_result", 32'(result), 32'd0);
        check("rst_valid", 32'(resultValid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_memory", 32'(memory), 32'd0);
        check("rst_ack", 32'(memWrAck), 32'd0);
        clearIn = 1'b0;

        runOp("add_3_4", 8'd3, 8'd4, 1'b0, 1'b0, 8'h07, 1'b0);
        runOp("sub_5_9", 8'd5, 8'd9, 1'b1, 1'b1, 8'hFC, 1'b0);
        runOp("add_100_100", 8'd100, 8'd100, 1'b0, 1'b0, 8'hC8, 1'b1);
        runOp("sub_80_1", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1);
        runOp("sub_0_1", 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0);

        // Second start while busy is dropped; SAVE during SHIFT is still written.
        expQ.push_back('{res: 8'h30, ov: 1'b0});
        issueStart(8'h10, 8'h20, 1'b0, 1'b0);
        repeat (3) @(negedge Clock);
        numberA   = 8'h7F;
        numberB   = 8'h7F;
        start     = 1'b1;
        memWrReq  = 1'b1;
        memWrData = 8'h3C;
        memQ.push_back(8'h3C);
        @(negedge Clock);
        start    = 1'b0;
        memWrReq = 1'b0;
        repeat (12) @(negedge Clock);
        check("drop_valid", 32'(resultValid), 32'd1);
        check("drop_result", 32'(result), 32'h30);
        check("drop_busy", 32'(busy), 32'd0);

        // autoSave result collides with SAVE in the DONE cycle.
        expQ.push_back('{res: 8'h46, ov: 1'b0});
        issueStart(8'h12, 8'h34, 1'b0, 1'b1);
        repeat (9) @(negedge Clock);
        memWrReq  = 1'b1;
        memWrData = 8'h55;
        memQ.push_back(8'h55);
        memQ.push_back(8'h46);
        @(negedge Clock);
        memWrReq = 1'b0;
        check("coll_ack1", 32'(memWrAck), 32'd1);
        check("coll_mem1", 32'(memory), 32'h55);
        check("coll_valid", 32'(resultValid), 32'd1);
        @(negedge Clock);
        check("coll_ack2", 32'(memWrAck), 32'd1);
        check("coll_mem2", 32'(memory), 32'h46);
        @(negedge Clock);
        check("coll_ack3", 32'(memWrAck), 32'd0);

        // Asynchronous clear mid-SHIFT aborts the operation.
        issueStart(8'h01, 8'h02, 1'b0, 1'b1);
        repeat (4) @(negedge Clock);
        clearIn = 1'b1;
        #1;
        check("clr_result", 32'(result), 32'd0);
        check("clr_valid", 32'(resultValid), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_memory", 32'(memory), 32'd0);
        check("clr_ack", 32'(memWrAck), 32'd0);
        @(negedge Clock);
        clearIn = 1'b0;
        repeat (12) @(negedge Clock);
        check("clr_nowrite", 32'(memory), 32'd0);
        check("clr_novalid", 32'(resultValid), 32'd0);

        runOp("after_clr", 8'h22, 8'h11, 1'b1, 1'b0, 8'h11, 1'b0);
        repeat (3) @(negedge Clock);
        check("expq_empty", 32'(expQ.size()), 32'd0);
        check("memq_empty", 32'(memQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
